// File: rtl/apb_bridge_pkg.sv
// Shared state encoding and address-map defaults for the APB side of the AHB-to-APB bridge.
// Pure declarations: no latency, no backpressure.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int          NUM_SLAVES      = 3;
  localparam int          DEF_REGION_LOG2 = 26;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;

endpackage

// File: rtl/apb_addr_decode.sv
// Address to one-hot APB slave select; combinational, zero latency, no backpressure.
// Only the bits at and above the region boundary are needed, so only those are passed in.
module apb_addr_decode import apb_bridge_pkg::*; #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    REGION_LOG2 = DEF_REGION_LOG2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic [ADDR_WIDTH-REGION_LOG2-1:0] addr_hi,
  output logic                              valid,
  output logic [NUM_SLAVES-1:0]             sel
);

  logic       base_hit;
  logic [1:0] idx;

  assign base_hit = (addr_hi[ADDR_WIDTH-REGION_LOG2-1:2] == BASE_ADDR[ADDR_WIDTH-1:REGION_LOG2+2]);
  assign idx      = addr_hi[1:0];

  // Region index 3 lies inside the base window but has no slave behind it.
  always_comb begin
    sel = '0;
    if (base_hit) begin
      case (idx)
        2'd0:    sel = 3'b001;
        2'd1:    sel = 3'b010;
        2'd2:    sel = 3'b100;
        default: sel = '0;
      endcase
    end
  end

  assign valid = |sel;

endmodule

// File: rtl/apb_controller.sv
// APB initiator: one-entry request buffer, SETUP/ACCESS sequencing; accept->response 4 cycles, 1 transfer / 2 cycles.
// Backpressure: req_ready is low while the buffer holds an undrained request.
module apb_controller import apb_bridge_pkg::*; #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    REGION_LOG2 = DEF_REGION_LOG2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  Pwrite,
  output logic [NUM_SLAVES-1:0] Pselx,
  output logic                  Penable,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata,
  input  logic [DATA_WIDTH-1:0] Prdata
);

  typedef struct packed {
    logic                  write;
    logic                  hit;
    logic [NUM_SLAVES-1:0] sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  apb_state_e            state_q, state_d;
  logic                  buf_valid_q, buf_valid_d;
  req_t                  buf_q, buf_d;
  logic [NUM_SLAVES-1:0] pselx_q, pselx_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  err_pend_q, err_pend_d;
  logic                  launch;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel;

  apb_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REGION_LOG2 (REGION_LOG2),
    .BASE_ADDR   (BASE_ADDR)
  ) u_addr_decode (
    .addr_hi (req_addr[ADDR_WIDTH-1:REGION_LOG2]),
    .valid   (dec_hit),
    .sel     (dec_sel)
  );

  assign req_ready = !buf_valid_q;

  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_d        = buf_q;
    pselx_d      = pselx_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    resp_valid_d = err_pend_q;
    resp_err_d   = err_pend_q;
    resp_rdata_d = '0;
    err_pend_d   = 1'b0;
    launch       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (buf_valid_q) begin
          buf_valid_d = 1'b0;
          if (buf_q.hit) begin
            launch = 1'b1;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = pwrite_q ? '0 : Prdata;
        state_d      = IDLE;
        pselx_d      = '0;
        penable_d    = 1'b0;
        // A bad entry drained here answers one cycle after the APB response.
        if (buf_valid_q) begin
          buf_valid_d = 1'b0;
          if (buf_q.hit) begin
            launch = 1'b1;
          end else begin
            err_pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d   = SETUP;
      pselx_d   = buf_q.sel;
      penable_d = 1'b0;
      pwrite_d  = buf_q.write;
      paddr_d   = buf_q.addr;
      pwdata_d  = buf_q.wdata;
    end

    if (req_valid && req_ready) begin
      buf_valid_d = 1'b1;
      buf_d.write = req_write;
      buf_d.hit   = dec_hit;
      buf_d.sel   = dec_sel;
      buf_d.addr  = req_addr;
      buf_d.wdata = req_wdata;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q      <= IDLE;
      buf_valid_q  <= 1'b0;
      buf_q        <= '0;
      pselx_q      <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      err_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_q        <= buf_d;
      pselx_q      <= pselx_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      err_pend_q   <= err_pend_d;
    end
  end

  assign Pselx      = pselx_q;
  assign Penable    = penable_q;
  assign Pwrite     = pwrite_q;
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: directed cycle-exact steps, then random traffic against a transaction-level address-map model.
module tb_apb_controller;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        Pwrite;
  logic [2:0]  Pselx;
  logic        Penable;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  always #5 Hclk = ~Hclk;

  apb_controller dut (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .Pwrite     (Pwrite),
    .Pselx      (Pselx),
    .Penable    (Penable),
    .Paddr      (Paddr),
    .Pwdata     (Pwdata),
    .Prdata     (Prdata)
  );

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        err;
    logic [2:0]  sel;
    logic        seen;
  } txn_t;

  txn_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Slaves occupy three consecutive 64 MB windows starting at 0x8000_0000.
  function automatic txn_t model(input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    longint unsigned base = 64'h8000_0000;
    longint unsigned span = 64'd1 << 26;
    longint unsigned ua   = {32'd0, a};
    t.w = w; t.a = a; t.d = d; t.rd = '0; t.seen = 1'b0;
    if (ua >= base && ua < base + 3 * span) begin
      t.err = 1'b0;
      t.sel = 3'b001 << ((ua - base) / span);
    end else begin
      t.err = 1'b1;
      t.sel = 3'b000;
    end
    return t;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] off = $urandom & 32'h03FF_FFFF;
    case ($urandom_range(0, 7))
      0, 1:    return 32'h8000_0000 | off;
      2, 3:    return 32'h8400_0000 | off;
      4, 5:    return 32'h8800_0000 | off;
      6:       return 32'h8C00_0000 | off;
      default: return $urandom & 32'h7FFF_FFFF;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] err_addrs [2];
  txn_t        t;
  logic [2:0]  prev_sel;
  logic        prev_pen;
  logic        access_now;

  initial begin
    Hreset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; Prdata = '0;
    repeat (3) tick();
    Hreset = 1'b0;
    #1;
    chk("rst_pselx", Pselx, 0);       chk("rst_penable", Penable, 0);
    chk("rst_pwrite", Pwrite, 0);     chk("rst_paddr", Paddr, 0);
    chk("rst_pwdata", Pwdata, 0);     chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0); chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);

    // Single write to slave 1
    offer(1'b1, 32'h8400_0010, 32'hDEAD_BEEF);
    tick(); req_valid = 1'b0;
    chk("wr_c1_ready", req_ready, 0); chk("wr_c1_pselx", Pselx, 0);
    tick();
    chk("wr_c2_pselx", Pselx, 3'b010); chk("wr_c2_penable", Penable, 0);
    chk("wr_c2_pwrite", Pwrite, 1);    chk("wr_c2_paddr", Paddr, 32'h8400_0010);
    chk("wr_c2_pwdata", Pwdata, 32'hDEAD_BEEF); chk("wr_c2_ready", req_ready, 1);
    tick();
    chk("wr_c3_penable", Penable, 1); chk("wr_c3_pselx", Pselx, 3'b010);
    chk("wr_c3_resp_valid", resp_valid, 0);
    tick();
    chk("wr_c4_resp_valid", resp_valid, 1); chk("wr_c4_resp_err", resp_err, 0);
    chk("wr_c4_resp_rdata", resp_rdata, 0); chk("wr_c4_pselx", Pselx, 0);
    chk("wr_c4_penable", Penable, 0);      chk("wr_c4_paddr_hold", Paddr, 32'h8400_0010);
    tick();
    chk("wr_c5_resp_valid", resp_valid, 0);

    // Read from slave 2
    Prdata = 32'h5A5A_0000;
    offer(1'b0, 32'h8800_0004, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    chk("rd_c2_pselx", Pselx, 3'b100); chk("rd_c2_pwrite", Pwrite, 0);
    Prdata = 32'h0000_00A5;
    tick();
    chk("rd_c3_penable", Penable, 1);
    tick();
    Prdata = 32'h1234_5678;
    chk("rd_c4_resp_valid", resp_valid, 1); chk("rd_c4_resp_rdata", resp_rdata, 32'h0000_00A5);
    chk("rd_c4_resp_err", resp_err, 0);
    tick();
    chk("rd_c5_resp_valid", resp_valid, 0);

    // Back-to-back reads, second offered during SETUP
    offer(1'b0, 32'h8000_0000, 32'h0);
    tick(); req_valid = 1'b0;
    tick();
    chk("b2b_c2_pselx", Pselx, 3'b001); chk("b2b_c2_penable", Penable, 0);
    chk("b2b_c2_ready", req_ready, 1);
    offer(1'b0, 32'h8400_0000, 32'h0);
    Prdata = 32'h0000_0011;
    tick(); req_valid = 1'b0;
    chk("b2b_c3_penable", Penable, 1); chk("b2b_c3_pselx", Pselx, 3'b001);
    tick();
    Prdata = 32'h0000_0022;
    chk("b2b_c4_resp_valid", resp_valid, 1); chk("b2b_c4_resp_rdata", resp_rdata, 32'h11);
    chk("b2b_c4_pselx", Pselx, 3'b010);      chk("b2b_c4_penable", Penable, 0);
    tick();
    chk("b2b_c5_penable", Penable, 1); chk("b2b_c5_resp_valid", resp_valid, 0);
    tick();
    chk("b2b_c6_resp_valid", resp_valid, 1); chk("b2b_c6_resp_rdata", resp_rdata, 32'h22);
    chk("b2b_c6_pselx", Pselx, 0);
    tick();

    // Decode errors: region index 3, then base mismatch
    err_addrs[0] = 32'h8C00_0000;
    err_addrs[1] = 32'h1000_0000;
    for (int i = 0; i < 2; i++) begin
      offer(i[0], err_addrs[i], 32'h1);
      tick(); req_valid = 1'b0;
      chk($sformatf("derr%0d_c1_pselx", i), Pselx, 0);
      chk($sformatf("derr%0d_c1_resp_valid", i), resp_valid, 0);
      tick();
      chk($sformatf("derr%0d_c2_resp_valid", i), resp_valid, 1);
      chk($sformatf("derr%0d_c2_resp_err", i), resp_err, 1);
      chk($sformatf("derr%0d_c2_resp_rdata", i), resp_rdata, 0);
      chk($sformatf("derr%0d_c2_pselx", i), Pselx, 0);
      chk($sformatf("derr%0d_c2_penable", i), Penable, 0);
      tick();
      chk($sformatf("derr%0d_c3_resp_valid", i), resp_valid, 0);
    end

    // Decode error drained while leaving ACCESS: APB response first, error one cycle later
    offer(1'b1, 32'h8000_0100, 32'h0000_CAFE);
    tick(); req_valid = 1'b0;
    tick();
    offer(1'b0, 32'h8C00_0004, 32'h0);
    tick(); req_valid = 1'b0;
    chk("eacc_c3_penable", Penable, 1);
    tick();
    chk("eacc_c4_resp_valid", resp_valid, 1); chk("eacc_c4_resp_err", resp_err, 0);
    chk("eacc_c4_pselx", Pselx, 0);           chk("eacc_c4_ready", req_ready, 1);
    tick();
    chk("eacc_c5_resp_valid", resp_valid, 1); chk("eacc_c5_resp_err", resp_err, 1);
    chk("eacc_c5_resp_rdata", resp_rdata, 0);
    tick();
    chk("eacc_c6_resp_valid", resp_valid, 0);

    // Reset asserted during ACCESS of a write
    offer(1'b1, 32'h8000_0020, 32'h0000_0055);
    tick(); req_valid = 1'b0;
    tick();
    tick();
    chk("mrst_c3_penable", Penable, 1);
    #2 Hreset = 1'b1;
    #1;
    chk("mrst_pselx", Pselx, 0);      chk("mrst_penable", Penable, 0);
    chk("mrst_resp_valid", resp_valid, 0); chk("mrst_ready", req_ready, 1);
    tick(); tick();
    chk("mrst_hold_resp_valid", resp_valid, 0);
    Hreset = 1'b0;
    tick();
    chk("mrst_post_resp_valid", resp_valid, 0);
    offer(1'b0, 32'h8400_0008, 32'h0);
    Prdata = 32'h0000_0077;
    tick(); req_valid = 1'b0;
    tick();
    chk("mrst_next_pselx", Pselx, 3'b010);
    tick();
    chk("mrst_next_penable", Penable, 1);
    tick();
    chk("mrst_next_resp_valid", resp_valid, 1); chk("mrst_next_resp_err", resp_err, 0);
    chk("mrst_next_resp_rdata", resp_rdata, 32'h77);
    tick();

    // Random traffic against the address-map model
    prev_sel = Pselx;
    prev_pen = Penable;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      access_now = 1'b0;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_resp", resp_valid, 0);
        end else begin
          t = exp_q.pop_front();
          chk("rnd_resp_err", resp_err, t.err);
          chk("rnd_resp_rdata", resp_rdata, (t.err || t.w) ? 32'h0 : t.rd);
          chk("rnd_resp_had_access", t.seen, !t.err);
        end
      end
      if (Penable) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_access", Penable, 0);
        end else begin
          chk("rnd_acc_pselx", Pselx, exp_q[0].sel);
          chk("rnd_acc_paddr", Paddr, exp_q[0].a);
          chk("rnd_acc_pwrite", Pwrite, exp_q[0].w);
          if (exp_q[0].w) chk("rnd_acc_pwdata", Pwdata, exp_q[0].d);
          chk("rnd_setup_pselx", prev_sel, Pselx);
          chk("rnd_setup_penable", prev_pen, 0);
          access_now = 1'b1;
        end
      end
      prev_sel = Pselx;
      prev_pen = Penable;

      Prdata = $urandom;
      if (access_now) begin
        exp_q[0].rd   = Prdata;
        exp_q[0].seen = 1'b1;
      end
      req_valid = (cyc < 2800) && ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = rand_addr();
      req_wdata = $urandom;
      if (req_valid && req_ready) exp_q.push_back(model(req_write, req_addr, req_wdata));
      tick();
    end
    req_valid = 1'b0;
    chk("rnd_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/apb_controller.md
Name: apb_controller

Overview:
- APB initiator FSM for the AHB-to-APB bridge; drives Pselx/Penable/Pwrite/Paddr/Pwdata into the APB interface/slave side and captures Prdata.
- Accepts transfer requests from the AHB slave side over a valid/ready handshake into a one-entry buffer, decodes the address to a one-hot slave select, and runs SETUP/ACCESS phases.
- Returns one response per request; back-to-back transfers run with no IDLE gap.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- REGION_LOG2, 26, log2 of the size of each slave region (64 MB).
- BASE_ADDR, 32'h8000_0000, base of slave 0; slaves 1 and 2 follow contiguously.

Ports:
- Hclk  in  1  clock; all state updates on its rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  buffer can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  transfer address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle pulse; response present.
- resp_err  out  1  decode error (qualified by resp_valid).
- resp_rdata  out  DATA_WIDTH  read data (qualified by resp_valid).
- Pwrite  out  1  APB write.
- Pselx  out  3  one-hot APB slave select.
- Penable  out  1  APB enable.
- Paddr  out  ADDR_WIDTH  APB address.
- Pwdata  out  DATA_WIDTH  APB write data.
- Prdata  in  DATA_WIDTH  APB read data.

Behaviour:
- Reset: Hreset is asynchronous and active-high. Asserting it at any time, mid-transfer included, forces the following immediately: state IDLE, buffer empty, all APB outputs 0, resp_valid/resp_err/resp_rdata 0. An in-flight transfer is dropped with no response.
- Handshake:
  - req_ready = !buf_valid, combinational from a register.
  - A request is accepted at an edge where req_valid && req_ready. The buffer stores write, addr, wdata and the decoded select.
- Decode:
  - valid iff req_addr[ADDR_WIDTH-1:REGION_LOG2+2] == BASE_ADDR[ADDR_WIDTH-1:REGION_LOG2+2] and idx = req_addr[REGION_LOG2+1:REGION_LOG2] < 3.
  - sel = 1 << idx. Index 3 or a base mismatch gives sel = 0 (decode error).
- FSM:
  - IDLE -> SETUP when buf_valid and sel != 0.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> SETUP if buf_valid and sel != 0; otherwise ACCESS -> IDLE.
  - There is no Pready; ACCESS always lasts exactly one cycle.
- Entering SETUP:
  - Pselx = sel, Paddr/Pwrite/Pwdata load from the buffer, Penable = 0.
  - The buffer empties on the same edge, so req_ready rises in the SETUP cycle.
- ACCESS: Penable = 1; Pselx/Paddr/Pwrite/Pwdata are held stable.
- Leaving ACCESS:
  - resp_valid = 1 for the next cycle only; resp_err = 0.
  - resp_rdata = Prdata if a read, 0 if a write.
  - Going to IDLE: Pselx = 0 and Penable = 0. Paddr/Pwdata/Pwrite hold their last values.
- Decode-error entry (sel = 0), in IDLE or ACCESS:
  - Consumed on that edge with no APB activity.
  - Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0.
  - FSM goes to or stays in IDLE. If the error entry is consumed while leaving ACCESS, the APB response comes first and the error response one cycle later; resp_valid is never merged.
- Latency (accept edge = cycle 0): buf_valid in cycle 1; SETUP in cycle 2; ACCESS in cycle 3; resp_valid in cycle 4.
- Throughput: one transfer per 2 cycles when the buffer is refilled during SETUP.
- Simultaneous events: an accept in the same edge as the buffer drain cannot happen, because req_ready is from the registered buf_valid. A new request offered during SETUP is accepted at the SETUP->ACCESS edge.

Decomposition:
- Package apb_bridge_pkg: state enum (IDLE, SETUP, ACCESS), NUM_SLAVES = 3, default BASE_ADDR, default REGION_LOG2.
- One natural sub-module: apb_addr_decode, the combinational addr -> {valid, one-hot sel}. Everything else stays in apb_controller.

Test Plan:
- Reset: hold Hreset high for 3 cycles then release -> all outputs 0, req_ready = 1, state IDLE.
- Single write: addr 32'h8400_0010, wdata 32'hDEAD_BEEF -> cycle 2 Pselx = 3'b010, Penable = 0, Pwrite = 1. Cycle 3 Penable = 1. Cycle 4 resp_valid = 1, resp_err = 0, resp_rdata = 0.
- Read from slave 2: addr 32'h8800_0004, Prdata = 32'h0000_00A5 during ACCESS -> Pselx = 3'b100. resp_rdata = 32'h0000_00A5 with resp_valid for exactly 1 cycle.
- Back-to-back: reads to 32'h8000_0000 then 32'h8400_0000, the second offered while in SETUP -> ACCESS goes directly to SETUP with no IDLE. Pselx goes 001 then 010. Responses arrive 2 cycles apart.
- Decode errors:
  - addr 32'h8C00_0000 (idx 3) -> no Pselx activity; resp_valid = 1, resp_err = 1 in cycle 2.
  - addr 32'h1000_0000 (base mismatch) -> same response.
- Reset mid-ACCESS: assert Hreset during the ACCESS of a write -> Pselx/Penable drop to 0 immediately, no resp_valid. The next request after release completes normally.
